// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared types and constants for the HD44780 LCD bus controller.
//   - lcd_state_e : bus-timing FSM states
//   - ADDR_*      : Avalon-MM word addresses
//   - STAT_*      : bit positions in the status word
//   - OP_*        : clear/home opcodes that need the long execution delay
//   - lcd_entry_t : one queued byte {rs, data}
// The long-delay helper is only referenced when LCD_BUS_CTRL_LONG_DELAY_EN is defined.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CMD  = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_NEMPTY = 1;
  localparam int STAT_FULL   = 2;
  localparam int STAT_OVF    = 3;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and return-home are the only commands that run for ~1.6 ms.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: small synchronous FIFO holding queued LCD bytes.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   push_i/din_i : write an entry (ignored when full)
//   pop_i/dout_o : dout_o shows the head entry; pop_i advances it (ignored when empty)
//   full_o       : level == DEPTH
//   empty_o      : level == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  logic [W-1:0] mem_q [DEPTH];
  ptr_t         wr_ptr_q, rd_ptr_q;
  lvl_t         level_q;
  logic         do_push, do_pop;

  assign full_o  = (level_q == lvl_t'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + lvl_t'(1);
        2'b01:   level_q <= level_q - lvl_t'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// lcd_bus_ctrl: Avalon-MM slave that queues HD44780 command/data bytes and
// generates the LCD bus timing (RS, E, DB) in hardware.
//   clk, reset_n           : clock, async active-low reset
//   address/chipselect/
//   write_n/writedata      : Avalon-MM write port (only writedata[7:0] used)
//   readdata               : combinational read data (status at address 2)
//   lcd_data/lcd_rs/
//   lcd_rw/lcd_en          : LCD connector pins (lcd_rw tied low)
// Register map: 0 = data byte (rs=1), 1 = command byte (rs=0),
//   2 = status {ovf, full, empty_n, busy} (write clears ovf), 3 = reserved.
// Optional: LCD_BUS_CTRL_LONG_DELAY_EN makes clear/home commands wait
// T_LONG_CYC after E instead of T_EXEC_CYC.
module lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_LONG_CYC  = 80000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en
);

  // Counter covers every configured delay so its width is the same with or
  // without the long-delay option.
  localparam int MAX_DLY = max2(max2(max2(T_SETUP_CYC, T_EN_CYC),
                                     max2(T_HOLD_CYC, T_EXEC_CYC)), T_LONG_CYC);
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d, exec_dly;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       en_q, en_d;
  logic       ovf_q, ovf_d;

  logic       wr_en, push_req, pop, cnt_exp, busy;
  logic       fifo_full, fifo_empty;
  lcd_entry_t fifo_din, fifo_dout;
  logic       unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  // ---------------- bus write side ----------------
  assign wr_en    = chipselect && !write_n;
  assign push_req = wr_en && (address == ADDR_DATA || address == ADDR_CMD);
  assign fifo_din = '{rs: (address == ADDR_DATA), data: writedata[7:0]};

  // Fullness is taken before the edge, so a push that meets a full FIFO is
  // dropped even if the FSM pops in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && address == ADDR_STAT) ovf_d = 1'b0;
    else if (push_req && fifo_full)    ovf_d = 1'b1;
  end

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(lcd_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- bus timing FSM ----------------
  // A load of N keeps the state for exactly N cycles.
  assign cnt_exp = (cnt_q <= cnt_t'(1));

`ifdef LCD_BUS_CTRL_LONG_DELAY_EN
  assign exec_dly = is_long_cmd(rs_q, data_q) ? cnt_t'(T_LONG_CYC) : cnt_t'(T_EXEC_CYC);
`else
  assign exec_dly = cnt_t'(T_EXEC_CYC);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          rs_d    = fifo_dout.rs;
          data_d  = fifo_dout.data;
          cnt_d   = cnt_t'(T_SETUP_CYC);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_exp) begin
          cnt_d   = cnt_t'(T_EN_CYC);
          state_d = ST_ENABLE;
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      ST_ENABLE: begin
        if (cnt_exp) begin
          cnt_d   = cnt_t'(T_HOLD_CYC);
          state_d = ST_HOLD;
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      ST_HOLD: begin
        if (cnt_exp) begin
          cnt_d   = exec_dly;
          state_d = ST_EXEC;
        end else cnt_d = cnt_q - cnt_t'(1);
      end
      ST_EXEC: begin
        if (cnt_exp) state_d = ST_IDLE;
        else         cnt_d   = cnt_q - cnt_t'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // E comes straight from a flop so the strobe cannot glitch.
  assign en_d = (state_d == ST_ENABLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- outputs ----------------
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_en   = en_q;
  assign lcd_rw   = 1'b0;

  always_comb begin
    readdata = '0;
    if (address == ADDR_STAT) begin
      readdata[STAT_BUSY]   = busy;
      readdata[STAT_NEMPTY] = !fifo_empty;
      readdata[STAT_FULL]   = fifo_full;
      readdata[STAT_OVF]    = ovf_q;
    end
  end

endmodule
